mgt_reset_sequencer: RTL and testbench
======================================

# mgt_reset_sequencer

Startup and recovery sequencer for one trigger-link transceiver, in the `clock_40` domain. It drives the PLL reset, MGT reset, TX reset and realign controls in a fixed order, waiting on PLL lock and TX reset-done. It retries a bounded number of times on timeout and reports link readiness. It replaces the free-running ipbus-driven reset bits as the normal source of these controls; each TMR copy instantiates one sequencer and votes its outputs.

## Interface
Parameters:
- `PLL_RESET_CYCLES`, 16: width in cycles of the PLL reset pulse.
- `PLL_LOCK_TIMEOUT`, 4096: maximum cycles to wait for `pll_lock_i`.
- `MGT_RESET_CYCLES`, 16: width in cycles of the MGT/TX reset pulse.
- `RESETDONE_TIMEOUT`, 4096: maximum cycles to wait for `tx_resetdone_i`.
- `REALIGN_CYCLES`, 4: width in cycles of the realign pulse.
- `MAX_RETRIES`, 3: retries allowed after a timeout (range 0–3).
- `ALLOW_RETRY`, 1: if 0, any timeout goes straight to FAIL.
- All cycle parameters are in the range 1–65535.

Ports:
- `clock_40` in 1: the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle request to (re)run the full sequence.
- `pll_lock_i` in 1: PLL lock, already synchronised to `clock_40`.
- `tx_resetdone_i` in 1: TX reset done, already synchronised.
- `force_not_ready` in 1: masks `ready_o`.
- `pll_reset_o` out 1: PLL reset.
- `mgt_reset_o` out 4: MGT reset bits.
- `txreset_o` out 1: TX reset.
- `mgt_realign_o` out 1: realign strobe.
- `ready_o` out 1: link ready.
- `busy_o` out 1: sequence in progress.
- `fail_o` out 1: retries exhausted.
- `retry_cnt_o` out 2: retries used in the current sequence.
- `state_o` out 3: state encoding, for debug.

## Operation
States and encodings: IDLE=0, PLL_RST=1, PLL_WAIT=2, MGT_RST=3, DONE_WAIT=4, REALIGN=5, READY=6, FAIL=7.

Timer:
- 16-bit up-counter, cleared on every state transition, otherwise incremented.
- "Timer = N−1" means N cycles have elapsed in the current state.

Transitions:
- IDLE → PLL_RST when `start_i` = 1.
- PLL_RST → PLL_WAIT at timer = `PLL_RESET_CYCLES`−1.
- PLL_WAIT:
  - `pll_lock_i` = 1 → MGT_RST.
  - Otherwise, at timer = `PLL_LOCK_TIMEOUT`−1 → timeout.
  - Lock takes priority over timeout in the same cycle.
- MGT_RST → DONE_WAIT at timer = `MGT_RESET_CYCLES`−1.
- DONE_WAIT:
  - `tx_resetdone_i` = 1 → REALIGN.
  - Otherwise, at timer = `RESETDONE_TIMEOUT`−1 → timeout.
  - Done takes priority over timeout.
- REALIGN → READY at timer = `REALIGN_CYCLES`−1.
- READY → PLL_RST if `pll_lock_i` = 0 (loss of lock); `retry_cnt` is cleared.
- FAIL: stays in FAIL until `start_i` or `reset_i`.

Timeout handling:
- If `ALLOW_RETRY` = 1 and `retry_cnt` < `MAX_RETRIES`: increment `retry_cnt` and go to PLL_RST.
- Otherwise go to FAIL.

`start_i` in any state:
- Go to PLL_RST and clear `retry_cnt` (abort and restart).
- `start_i` takes priority over every other transition, including lock, done and timeout in the same cycle.

Outputs are pure decodes of the state register (no extra latency):
- `pll_reset_o` = (state == PLL_RST).
- `mgt_reset_o` = 4'b1111 and `txreset_o` = 1 when state == MGT_RST; otherwise 4'b0000 and 0.
- `mgt_realign_o` = (state == REALIGN).
- `ready_o` = (state == READY) & ~`force_not_ready`. `force_not_ready` does not change state.
- `busy_o` = state ∈ {1..5}.
- `fail_o` = (state == FAIL).

## Timing
- Reset (`reset_i` = 1 sampled on a clock edge):
  - Next cycle: state = IDLE, timer = 0, `retry_cnt` = 0.
  - All outputs 0, `state_o` = 0.
  - Applies identically mid-sequence: an asserted `pll_reset_o` or `mgt_reset_o` drops the cycle after reset is sampled.
- `start_i` sampled high in cycle 0:
  - `pll_reset_o` = 1 in cycles 1 .. `PLL_RESET_CYCLES`.
  - State is PLL_WAIT from cycle `PLL_RESET_CYCLES`+1.
- Lock sampled high in PLL_WAIT cycle k: MGT_RST begins the next cycle and lasts exactly `MGT_RESET_CYCLES` cycles.
- Best case with default parameters and lock/done already high: `ready_o` rises in cycle 1+16+1+16+1+4 = 39 after `start_i`.
- Loss of lock in READY: `ready_o` falls and `pll_reset_o` rises in the cycle after `pll_lock_i` is sampled low.
- The timer never wraps, because every state exits at or before its own limit.

## Test plan
- Nominal: defaults, lock and resetdone tied high, `start_i` pulse → `pll_reset_o` high for 16 cycles, `mgt_reset_o` = 4'hF for 16 cycles, realign for 4 cycles, `ready_o` = 1 at cycle 39, `retry_cnt_o` = 0.
- Lock timeout exhaustion: `pll_lock_i` held 0, `PLL_LOCK_TIMEOUT` = 8 → 4 PLL reset pulses, `retry_cnt_o` steps 1, 2, 3, then `fail_o` = 1 and `state_o` = 7; a later `start_i` → `retry_cnt_o` = 0 and a new PLL pulse.
- Resetdone recovery: `tx_resetdone_i` low for the first attempt, high after → exactly one retry, `retry_cnt_o` = 1, `ready_o` = 1.
- Loss of lock: in READY, drop `pll_lock_i` for 1 cycle → next cycle `ready_o` = 0, `pll_reset_o` = 1, `retry_cnt_o` = 0, and the sequence re-completes.
- Abort and reset: `start_i` during DONE_WAIT → PLL_RST next cycle; `reset_i` during MGT_RST → all outputs 0 next cycle and state IDLE.
- Masking and no retry: `force_not_ready` = 1 in READY → `ready_o` = 0 while `state_o` stays 6; with `ALLOW_RETRY` = 0, the first timeout → FAIL.

Source files
------------

// File: rtl/mgt_reset_sequencer.sv
// Startup/recovery sequencer for one trigger-link transceiver (clock_40 domain).
// Steps PLL reset -> lock wait -> MGT/TX reset -> resetdone wait -> realign,
// retrying a bounded number of times on timeout and reporting readiness.
module mgt_reset_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES  = 16,
    parameter int unsigned PLL_LOCK_TIMEOUT  = 4096,
    parameter int unsigned MGT_RESET_CYCLES  = 16,
    parameter int unsigned RESETDONE_TIMEOUT = 4096,
    parameter int unsigned REALIGN_CYCLES    = 4,
    parameter int unsigned MAX_RETRIES       = 3,
    parameter int unsigned ALLOW_RETRY       = 1
) (
    input  logic       clock_40,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       pll_lock_i,
    input  logic       tx_resetdone_i,
    input  logic       force_not_ready,
    output logic       pll_reset_o,
    output logic [3:0] mgt_reset_o,
    output logic       txreset_o,
    output logic       mgt_realign_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        PLL_WAIT  = 3'd2,
        MGT_RST   = 3'd3,
        DONE_WAIT = 3'd4,
        REALIGN   = 3'd5,
        READY     = 3'd6,
        FAIL      = 3'd7
    } state_t;

    // Last timer value of each timed state ("timer = N-1" means N cycles elapsed).
    localparam logic [15:0] PLL_RST_LAST  = 16'(PLL_RESET_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST     = 16'(PLL_LOCK_TIMEOUT - 1);
    localparam logic [15:0] MGT_RST_LAST  = 16'(MGT_RESET_CYCLES - 1);
    localparam logic [15:0] DONE_LAST     = 16'(RESETDONE_TIMEOUT - 1);
    localparam logic [15:0] REALIGN_LAST  = 16'(REALIGN_CYCLES - 1);
    localparam logic [1:0]  MAX_RETRY_CNT = 2'(MAX_RETRIES);
    localparam logic        RETRY_EN      = (ALLOW_RETRY != 0);

    state_t      state, state_next;
    logic [15:0] timer;
    logic [1:0]  retry_cnt, retry_next;
    logic        timer_clr;
    logic        timeout;

    // State, timer and retry counter registers with synchronous reset.
    always_ff @(posedge clock_40) begin
        if (reset_i) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_next;
            if (timer_clr)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 16'd1;
        end
    end

    // Next-state, retry bookkeeping and timer clear; start_i overrides everything.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        timeout    = 1'b0;
        timer_clr  = 1'b0;

        if (start_i) begin
            state_next = PLL_RST;
            retry_next = '0;
            timer_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                PLL_RST: begin
                    if (timer == PLL_RST_LAST)
                        state_next = PLL_WAIT;
                end
                PLL_WAIT: begin
                    if (pll_lock_i)
                        state_next = MGT_RST;
                    else if (timer == LOCK_LAST)
                        timeout = 1'b1;
                end
                MGT_RST: begin
                    if (timer == MGT_RST_LAST)
                        state_next = DONE_WAIT;
                end
                DONE_WAIT: begin
                    if (tx_resetdone_i)
                        state_next = REALIGN;
                    else if (timer == DONE_LAST)
                        timeout = 1'b1;
                end
                REALIGN: begin
                    if (timer == REALIGN_LAST)
                        state_next = READY;
                end
                READY: begin
                    if (!pll_lock_i) begin
                        state_next = PLL_RST;
                        retry_next = '0;
                    end
                end
                FAIL: ;
                default: state_next = IDLE;
            endcase

            if (timeout) begin
                if (RETRY_EN && (retry_cnt < MAX_RETRY_CNT)) begin
                    state_next = PLL_RST;
                    retry_next = retry_cnt + 2'd1;
                end else begin
                    state_next = FAIL;
                end
            end

            if (state_next != state)
                timer_clr = 1'b1;
        end
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        pll_reset_o   = (state == PLL_RST);
        mgt_reset_o   = (state == MGT_RST) ? 4'b1111 : 4'b0000;
        txreset_o     = (state == MGT_RST);
        mgt_realign_o = (state == REALIGN);
        ready_o       = (state == READY) && !force_not_ready;
        busy_o        = (state == PLL_RST) || (state == PLL_WAIT) || (state == MGT_RST) ||
                        (state == DONE_WAIT) || (state == REALIGN);
        fail_o        = (state == FAIL);
        retry_cnt_o   = retry_cnt;
        state_o       = state;
    end

endmodule

// File: tb/tb_mgt_reset_sequencer.sv
// Directed self-checking bench for mgt_reset_sequencer: three instances
// (defaults, short timeouts, short timeouts without retry) sharing the inputs.
`timescale 1ns/1ps
module tb_mgt_reset_sequencer;

    logic clk = 1'b0;
    logic reset, lock, done, force_nr;
    logic start_a, start_b, start_c;

    logic       pr_a, pr_b, pr_c;
    logic [3:0] mr_a, mr_b, mr_c;
    logic       tr_a, tr_b, tr_c;
    logic       ra_a, ra_b, ra_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       bsy_a, bsy_b, bsy_c;
    logic       fl_a, fl_b, fl_c;
    logic [1:0] rc_a, rc_b, rc_c;
    logic [2:0] st_a, st_b, st_c;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    mgt_reset_sequencer u_a (
        .clock_40(clk), .reset_i(reset), .start_i(start_a), .pll_lock_i(lock),
        .tx_resetdone_i(done), .force_not_ready(force_nr),
        .pll_reset_o(pr_a), .mgt_reset_o(mr_a), .txreset_o(tr_a), .mgt_realign_o(ra_a),
        .ready_o(rdy_a), .busy_o(bsy_a), .fail_o(fl_a), .retry_cnt_o(rc_a), .state_o(st_a)
    );

    mgt_reset_sequencer #(
        .PLL_RESET_CYCLES(4), .PLL_LOCK_TIMEOUT(8), .MGT_RESET_CYCLES(4),
        .RESETDONE_TIMEOUT(8), .REALIGN_CYCLES(2), .MAX_RETRIES(3), .ALLOW_RETRY(1)
    ) u_b (
        .clock_40(clk), .reset_i(reset), .start_i(start_b), .pll_lock_i(lock),
        .tx_resetdone_i(done), .force_not_ready(force_nr),
        .pll_reset_o(pr_b), .mgt_reset_o(mr_b), .txreset_o(tr_b), .mgt_realign_o(ra_b),
        .ready_o(rdy_b), .busy_o(bsy_b), .fail_o(fl_b), .retry_cnt_o(rc_b), .state_o(st_b)
    );

    mgt_reset_sequencer #(
        .PLL_RESET_CYCLES(4), .PLL_LOCK_TIMEOUT(8), .MGT_RESET_CYCLES(4),
        .RESETDONE_TIMEOUT(8), .REALIGN_CYCLES(2), .MAX_RETRIES(3), .ALLOW_RETRY(0)
    ) u_c (
        .clock_40(clk), .reset_i(reset), .start_i(start_c), .pll_lock_i(lock),
        .tx_resetdone_i(done), .force_not_ready(force_nr),
        .pll_reset_o(pr_c), .mgt_reset_o(mr_c), .txreset_o(tr_c), .mgt_realign_o(ra_c),
        .ready_o(rdy_c), .busy_o(bsy_c), .fail_o(fl_c), .retry_cnt_o(rc_c), .state_o(st_c)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; lock = 1'b1; done = 1'b1; force_nr = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset state
        chk("rst_state", 32'(st_a), 0);
        chk("rst_pll", 32'(pr_a), 0);
        chk("rst_mgt", 32'(mr_a), 0);
        chk("rst_busy", 32'(bsy_a), 0);
        chk("rst_ready", 32'(rdy_a), 0);
        chk("rst_fail", 32'(fl_a), 0);
        chk("rst_retry", 32'(rc_a), 0);

        // Nominal sequence on defaults: start sampled, now in cycle 1
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("nom_pll_pulse", 32'(pr_a), 1);
            chk("nom_busy", 32'(bsy_a), 1);
            tick();
        end
        chk("nom_pll_wait", 32'(st_a), 2);
        chk("nom_pll_low", 32'(pr_a), 0);
        tick();
        for (int i = 18; i <= 33; i++) begin
            chk("nom_mgt", 32'(mr_a), 32'hF);
            chk("nom_txrst", 32'(tr_a), 1);
            tick();
        end
        chk("nom_done_wait", 32'(st_a), 4);
        chk("nom_mgt_low", 32'(mr_a), 0);
        tick();
        for (int i = 35; i <= 38; i++) begin
            chk("nom_realign", 32'(ra_a), 1);
            chk("nom_not_ready", 32'(rdy_a), 0);
            tick();
        end
        chk("nom_ready39", 32'(rdy_a), 1);
        chk("nom_state6", 32'(st_a), 6);
        chk("nom_retry0", 32'(rc_a), 0);
        chk("nom_not_busy", 32'(bsy_a), 0);
        chk("nom_realign_low", 32'(ra_a), 0);

        // force_not_ready masks ready without moving the state
        force_nr = 1'b1; #1;
        chk("mask_ready", 32'(rdy_a), 0);
        tick();
        chk("mask_state", 32'(st_a), 6);
        force_nr = 1'b0; #1;
        chk("unmask_ready", 32'(rdy_a), 1);

        // Loss of lock for one cycle in READY
        lock = 1'b0; tick(); lock = 1'b1;
        chk("lol_ready", 32'(rdy_a), 0);
        chk("lol_pll", 32'(pr_a), 1);
        chk("lol_retry", 32'(rc_a), 0);
        tick(38);
        chk("lol_recomplete", 32'(rdy_a), 1);

        // Abort during DONE_WAIT, then reset during MGT_RST
        done = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(33);
        chk("abort_in_done_wait", 32'(st_a), 4);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("abort_state", 32'(st_a), 1);
        chk("abort_pll", 32'(pr_a), 1);
        tick(17);
        chk("mid_mgt_state", 32'(st_a), 3);
        chk("mid_mgt_rst", 32'(mr_a), 32'hF);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_state", 32'(st_a), 0);
        chk("midrst_mgt", 32'(mr_a), 0);
        chk("midrst_txrst", 32'(tr_a), 0);
        chk("midrst_pll", 32'(pr_a), 0);
        chk("midrst_busy", 32'(bsy_a), 0);
        done = 1'b1;

        // Lock timeout exhaustion (short timeouts): attempt n starts at cycle 1+12n
        lock = 1'b0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk("exh_pll_rise", 32'(pr_b), 1);
            chk("exh_retry", 32'(rc_b), 32'(n));
            tick(3);
            chk("exh_pll_last", 32'(pr_b), 1);
            tick();
            chk("exh_pll_wait", 32'(st_b), 2);
            tick(7);
            chk("exh_wait_end", 32'(st_b), 2);
            tick();
        end
        chk("exh_fail", 32'(fl_b), 1);
        chk("exh_state7", 32'(st_b), 7);
        chk("exh_retry3", 32'(rc_b), 3);
        chk("exh_not_busy", 32'(bsy_b), 0);
        tick(5);
        chk("exh_fail_sticky", 32'(st_b), 7);
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("exh_restart_retry", 32'(rc_b), 0);
        chk("exh_restart_pll", 32'(pr_b), 1);
        chk("exh_restart_nofail", 32'(fl_b), 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("exh_reset_idle", 32'(st_b), 0);

        // Resetdone recovery: first attempt times out in DONE_WAIT
        lock = 1'b1; done = 1'b0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(9);
        chk("rd_done_wait", 32'(st_b), 4);
        tick(7);
        chk("rd_wait_end", 32'(st_b), 4);
        tick();
        chk("rd_retry_state", 32'(st_b), 1);
        chk("rd_retry1", 32'(rc_b), 1);
        done = 1'b1;
        tick(11);
        chk("rd_not_yet", 32'(rdy_b), 0);
        tick();
        chk("rd_ready", 32'(rdy_b), 1);
        chk("rd_retry_kept", 32'(rc_b), 1);
        reset = 1'b1; tick(); reset = 1'b0;

        // No-retry instance: first lock timeout goes straight to FAIL
        lock = 1'b0;
        start_c = 1'b1; tick(); start_c = 1'b0;
        tick(11);
        chk("nr_wait_end", 32'(st_c), 2);
        tick();
        chk("nr_fail_state", 32'(st_c), 7);
        chk("nr_fail", 32'(fl_c), 1);
        chk("nr_retry0", 32'(rc_c), 0);
        chk("nr_no_pll", 32'(pr_c), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
